// File: rtl/accumulator_binary_multichannel.sv
// Bank of signed accumulators sharing one pipelined add/sub datapath.
// Ops are accepted per channel with a busy-bit hazard stall and reported on an output strobe.
module accumulator_binary_multichannel #(
    parameter int                    WORD_WIDTH    = 16,
    parameter int                    CHANNEL_COUNT = 4,
    parameter int                    CHANNEL_WIDTH = 2,
    parameter int                    PIPE_STAGES   = 1,
    parameter int                    SATURATE      = 0,
    parameter logic [WORD_WIDTH-1:0] INITIAL_VALUE = '0
) (
    input  logic                                clock,
    input  logic                                clear,
    input  logic                                input_valid,
    output logic                                input_ready,
    input  logic [CHANNEL_WIDTH-1:0]            input_channel,
    input  logic [1:0]                          input_op,
    input  logic [WORD_WIDTH-1:0]               input_value,
    output logic                                output_valid,
    output logic [CHANNEL_WIDTH-1:0]            output_channel,
    output logic [WORD_WIDTH-1:0]               output_value,
    output logic                                output_overflow,
    output logic [CHANNEL_COUNT*WORD_WIDTH-1:0] accumulated_values
);

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_RESET = 2'b11
    } op_e;

    localparam int LAST = PIPE_STAGES;
    localparam logic [WORD_WIDTH-1:0] MAX_VALUE = {1'b0, {(WORD_WIDTH-1){1'b1}}};
    localparam logic [WORD_WIDTH-1:0] MIN_VALUE = {1'b1, {(WORD_WIDTH-1){1'b0}}};

    logic [WORD_WIDTH-1:0]    acc_q [CHANNEL_COUNT];
    logic [WORD_WIDTH-1:0]    acc_d [CHANNEL_COUNT];
    logic [CHANNEL_COUNT-1:0] busy_q;
    logic [CHANNEL_COUNT-1:0] busy_d;

    logic                     stage_valid_q   [LAST+1];
    logic                     stage_valid_d   [LAST+1];
    op_e                      stage_op_q      [LAST+1];
    op_e                      stage_op_d      [LAST+1];
    logic [CHANNEL_WIDTH-1:0] stage_channel_q [LAST+1];
    logic [CHANNEL_WIDTH-1:0] stage_channel_d [LAST+1];
    logic [WORD_WIDTH-1:0]    stage_value_q   [LAST+1];
    logic [WORD_WIDTH-1:0]    stage_value_d   [LAST+1];
    logic [WORD_WIDTH-1:0]    stage_base_q    [LAST+1];
    logic [WORD_WIDTH-1:0]    stage_base_d    [LAST+1];

    logic                     output_valid_q;
    logic                     output_valid_d;
    logic [CHANNEL_WIDTH-1:0] output_channel_q;
    logic [CHANNEL_WIDTH-1:0] output_channel_d;
    logic [WORD_WIDTH-1:0]    output_value_q;
    logic [WORD_WIDTH-1:0]    output_value_d;
    logic                     output_overflow_q;
    logic                     output_overflow_d;

    logic                     channel_ok;
    logic                     channel_busy;
    logic [WORD_WIDTH-1:0]    channel_acc;
    logic                     accept;

    logic                     commit_valid;
    op_e                      commit_op;
    logic [CHANNEL_WIDTH-1:0] commit_channel;
    logic [WORD_WIDTH-1:0]    commit_a;
    logic [WORD_WIDTH-1:0]    commit_b;
    logic [WORD_WIDTH:0]      sum_ext;
    logic [WORD_WIDTH-1:0]    commit_result;
    logic                     commit_overflow;

    // Out-of-range channel indices never match, so they are never ready.
    always_comb begin
        channel_ok   = 1'b0;
        channel_busy = 1'b0;
        channel_acc  = '0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            if (input_channel == CHANNEL_WIDTH'(i)) begin
                channel_ok   = 1'b1;
                channel_busy = busy_q[i];
                channel_acc  = acc_q[i];
            end
        end
    end

    assign input_ready = !clear && channel_ok && !channel_busy;
    assign accept      = input_valid && input_ready;

    always_comb begin
        stage_valid_d[0]   = accept;
        stage_op_d[0]      = op_e'(input_op);
        stage_channel_d[0] = input_channel;
        stage_value_d[0]   = input_value;
        stage_base_d[0]    = channel_acc;
        for (int s = 1; s <= LAST; s++) begin
            stage_valid_d[s]   = stage_valid_q[s-1];
            stage_op_d[s]      = stage_op_q[s-1];
            stage_channel_d[s] = stage_channel_q[s-1];
            stage_value_d[s]   = stage_value_q[s-1];
            stage_base_d[s]    = stage_base_q[s-1];
        end
    end

    assign commit_valid   = stage_valid_q[LAST];
    assign commit_op      = stage_op_q[LAST];
    assign commit_channel = stage_channel_q[LAST];
    assign commit_a       = stage_base_q[LAST];
    assign commit_b       = stage_value_q[LAST];

    // One extra bit exposes signed overflow as a mismatch of the top two bits.
    always_comb begin
        sum_ext         = '0;
        commit_result   = INITIAL_VALUE;
        commit_overflow = 1'b0;
        unique case (commit_op)
            OP_ADD, OP_SUB: begin
                if (commit_op == OP_ADD) begin
                    sum_ext = {commit_a[WORD_WIDTH-1], commit_a} + {commit_b[WORD_WIDTH-1], commit_b};
                end else begin
                    sum_ext = {commit_a[WORD_WIDTH-1], commit_a} - {commit_b[WORD_WIDTH-1], commit_b};
                end
                commit_overflow = sum_ext[WORD_WIDTH] ^ sum_ext[WORD_WIDTH-1];
                if (commit_overflow && SATURATE != 0) begin
                    commit_result = sum_ext[WORD_WIDTH] ? MIN_VALUE : MAX_VALUE;
                end else begin
                    commit_result = sum_ext[WORD_WIDTH-1:0];
                end
            end
            OP_LOAD:  commit_result = commit_b;
            default:  commit_result = INITIAL_VALUE;
        endcase
    end

    // A committing channel is never the accepting one, so the busy updates never collide.
    always_comb begin
        acc_d             = acc_q;
        busy_d            = busy_q;
        output_valid_d    = commit_valid;
        output_channel_d  = output_channel_q;
        output_value_d    = output_value_q;
        output_overflow_d = output_overflow_q;
        if (commit_valid) begin
            output_channel_d  = commit_channel;
            output_value_d    = commit_result;
            output_overflow_d = commit_overflow;
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                if (commit_channel == CHANNEL_WIDTH'(i)) begin
                    acc_d[i]  = commit_result;
                    busy_d[i] = 1'b0;
                end
            end
        end
        if (accept) begin
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                if (input_channel == CHANNEL_WIDTH'(i)) begin
                    busy_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                acc_q[i] <= INITIAL_VALUE;
            end
            busy_q <= '0;
            for (int s = 0; s <= LAST; s++) begin
                stage_valid_q[s]   <= 1'b0;
                stage_op_q[s]      <= OP_ADD;
                stage_channel_q[s] <= '0;
                stage_value_q[s]   <= '0;
                stage_base_q[s]    <= '0;
            end
            output_valid_q    <= 1'b0;
            output_channel_q  <= '0;
            output_value_q    <= '0;
            output_overflow_q <= 1'b0;
        end else begin
            acc_q             <= acc_d;
            busy_q            <= busy_d;
            stage_valid_q     <= stage_valid_d;
            stage_op_q        <= stage_op_d;
            stage_channel_q   <= stage_channel_d;
            stage_value_q     <= stage_value_d;
            stage_base_q      <= stage_base_d;
            output_valid_q    <= output_valid_d;
            output_channel_q  <= output_channel_d;
            output_value_q    <= output_value_d;
            output_overflow_q <= output_overflow_d;
        end
    end

    assign output_valid    = output_valid_q;
    assign output_channel  = output_channel_q;
    assign output_value    = output_value_q;
    assign output_overflow = output_overflow_q;

    always_comb begin
        accumulated_values = '0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            accumulated_values[i*WORD_WIDTH +: WORD_WIDTH] = acc_q[i];
        end
    end

endmodule

// File: tb/tb_accumulator_binary_multichannel.sv
// Bench for accumulator_binary_multichannel: wrap and saturate instances share stimulus and are
// checked against a queue-based op model; a PIPE_STAGES=0 instance gets directed checks.
module tb_accumulator_binary_multichannel;

    localparam int W    = 8;
    localparam int CC   = 4;
    localparam int CW   = 2;
    localparam int LAT  = 3;
    localparam int MAXV = 127;
    localparam int MINV = -128;

    logic clock = 1'b0;
    logic clear;

    logic          in_valid;
    logic [CW-1:0] in_ch;
    logic [1:0]    in_op;
    logic [W-1:0]  in_val;

    logic            rdy, rdy_s, ov, ov_s, oovf, oovf_s;
    logic [CW-1:0]   och, och_s;
    logic [W-1:0]    oval, oval_s;
    logic [CC*W-1:0] accv, accv_s;

    logic        p_valid, p_rdy, p_ov, p_oovf;
    logic [1:0]  p_ch, p_op, p_och;
    logic [7:0]  p_val, p_oval;
    logic [23:0] p_acc;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    accumulator_binary_multichannel #(.WORD_WIDTH(W), .CHANNEL_COUNT(CC), .CHANNEL_WIDTH(CW),
        .PIPE_STAGES(1), .SATURATE(0), .INITIAL_VALUE(8'h00)) dut (
        .clock(clock), .clear(clear), .input_valid(in_valid), .input_ready(rdy),
        .input_channel(in_ch), .input_op(in_op), .input_value(in_val),
        .output_valid(ov), .output_channel(och), .output_value(oval),
        .output_overflow(oovf), .accumulated_values(accv));

    accumulator_binary_multichannel #(.WORD_WIDTH(W), .CHANNEL_COUNT(CC), .CHANNEL_WIDTH(CW),
        .PIPE_STAGES(1), .SATURATE(1), .INITIAL_VALUE(8'h00)) dut_sat (
        .clock(clock), .clear(clear), .input_valid(in_valid), .input_ready(rdy_s),
        .input_channel(in_ch), .input_op(in_op), .input_value(in_val),
        .output_valid(ov_s), .output_channel(och_s), .output_value(oval_s),
        .output_overflow(oovf_s), .accumulated_values(accv_s));

    accumulator_binary_multichannel #(.WORD_WIDTH(8), .CHANNEL_COUNT(3), .CHANNEL_WIDTH(2),
        .PIPE_STAGES(0), .SATURATE(0), .INITIAL_VALUE(8'h00)) dut_p0 (
        .clock(clock), .clear(clear), .input_valid(p_valid), .input_ready(p_rdy),
        .input_channel(p_ch), .input_op(p_op), .input_value(p_val),
        .output_valid(p_ov), .output_channel(p_och), .output_value(p_oval),
        .output_overflow(p_oovf), .accumulated_values(p_acc));

    // Reference model: accepted ops wait in a queue until their result becomes visible.
    typedef struct {
        int due;
        int ch;
        int op;
        int val;
    } pend_t;

    pend_t pend[$];
    pend_t cur;
    int    cyc = 0;
    int    free_at[CC];
    int    macc[CC];
    int    macc_s[CC];
    bit    o1, o2;

    logic            exp_valid, exp_ovf, exp_ovf_s;
    logic [CW-1:0]   exp_ch;
    logic [W-1:0]    exp_w, exp_s;
    logic [CC*W-1:0] exp_flat, exp_flat_s;

    function automatic int arith(int a, int b, int op, bit sat, output bit ovf);
        int r;
        ovf = 1'b0;
        if (op == 2) return b;
        if (op == 3) return 0;
        r = (op == 0) ? a + b : a - b;
        if (r > MAXV || r < MINV) begin
            ovf = 1'b1;
            if (sat) r = (r > MAXV) ? MAXV : MINV;
            else     r = (r > MAXV) ? r - 256 : r + 256;
        end
        return r;
    endfunction

    function automatic bit model_ready(logic clr, logic [CW-1:0] ch);
        return !clr && (cyc >= free_at[ch]);
    endfunction

    always @(posedge clock) begin
        if (clear) begin
            pend.delete();
            for (int i = 0; i < CC; i++) begin
                macc[i] = 0; macc_s[i] = 0; free_at[i] = 0;
            end
            exp_valid = 1'b0; exp_ch = '0; exp_w = '0; exp_s = '0;
            exp_ovf = 1'b0; exp_ovf_s = 1'b0;
            cyc++;
        end else begin
            if (in_valid && model_ready(1'b0, in_ch)) begin
                pend.push_back('{cyc + LAT, int'(in_ch), int'(in_op), int'($signed(in_val))});
                free_at[in_ch] = cyc + LAT;
            end
            cyc++;
            exp_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                cur = pend.pop_front();
                macc[cur.ch]   = arith(macc[cur.ch], cur.val, cur.op, 1'b0, o1);
                macc_s[cur.ch] = arith(macc_s[cur.ch], cur.val, cur.op, 1'b1, o2);
                exp_valid = 1'b1;
                exp_ch    = CW'(cur.ch);
                exp_w     = W'(macc[cur.ch]);
                exp_s     = W'(macc_s[cur.ch]);
                exp_ovf   = o1;
                exp_ovf_s = o2;
            end
        end
        for (int i = 0; i < CC; i++) begin
            exp_flat[i*W +: W]   = W'(macc[i]);
            exp_flat_s[i*W +: W] = W'(macc_s[i]);
        end
    end

    task automatic drive(logic v, int ch, int op, int val);
        in_valid = v;
        in_ch    = CW'(ch);
        in_op    = 2'(op);
        in_val   = W'(val);
    endtask

    task automatic test_reset();
        clear = 1'b1;
        drive(1'b0, 0, 0, 0);
        p_valid = 1'b0; p_ch = 2'd0; p_op = 2'd0; p_val = 8'd0;
        repeat (2) @(negedge clock);
        total++;
        if ({ov, och, oval, oovf} !== '0 || {ov_s, och_s, oval_s, oovf_s} !== '0 || p_ov !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset outputs: got %b/%b/%b want zero", {ov, och, oval, oovf}, {ov_s, och_s, oval_s, oovf_s}, p_ov);
        end
        total++;
        if (accv !== '0 || accv_s !== '0 || p_acc !== '0) begin
            bad++;
            $display("[TB] FAIL reset acc: got %h/%h/%h want 0", accv, accv_s, p_acc);
        end
        total++;
        if (rdy !== 1'b0 || rdy_s !== 1'b0 || p_rdy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ready during clear: got %b%b%b want 000", rdy, rdy_s, p_rdy);
        end
        clear = 1'b0;
        #1;
        total++;
        if (rdy !== 1'b1 || rdy_s !== 1'b1 || p_rdy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ready after clear: got %b%b%b want 111", rdy, rdy_s, p_rdy);
        end
    endtask

    task automatic test_directed();
        int chs[6]  = '{2, 0, 0, 1, 1, 1};
        int ops[6]  = '{0, 2, 0, 2, 1, 3};
        int vals[6] = '{5, 127, 1, -128, 1, 0};
        int idx = 0;
        bit go;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            total++;
            if (ov !== exp_valid || ov_s !== exp_valid) begin
                bad++;
                $display("[TB] FAIL directed valid: got %b/%b want %b", ov, ov_s, exp_valid);
            end
            if (exp_valid) begin
                total++;
                if ({och, oval, oovf} !== {exp_ch, exp_w, exp_ovf} || {och_s, oval_s, oovf_s} !== {exp_ch, exp_s, exp_ovf_s}) begin
                    bad++;
                    $display("[TB] FAIL directed result: got ch%0d %0d/%0d ovf %b/%b want ch%0d %0d/%0d ovf %b/%b",
                             och, $signed(oval), $signed(oval_s), oovf, oovf_s, exp_ch, $signed(exp_w), $signed(exp_s), exp_ovf, exp_ovf_s);
                end
            end
            total++;
            if (accv !== exp_flat || accv_s !== exp_flat_s) begin
                bad++;
                $display("[TB] FAIL directed acc: got %h/%h want %h/%h", accv, accv_s, exp_flat, exp_flat_s);
            end
            if (idx < 6) drive(1'b1, chs[idx], ops[idx], vals[idx]);
            else         drive(1'b0, 0, 0, 0);
            #1;
            go = model_ready(clear, in_ch);
            total++;
            if (rdy !== go || rdy_s !== go) begin
                bad++;
                $display("[TB] FAIL directed ready: got %b/%b want %b", rdy, rdy_s, go);
            end
            if (in_valid && go) idx++;
        end
        total++;
        if (accv !== 32'h0005_0080 || accv_s !== 32'h0005_007F) begin
            bad++;
            $display("[TB] FAIL directed final: got %h/%h want 00050080/0005007f", accv, accv_s);
        end
    endtask

    task automatic test_back_to_back();
        int count = 0;
        bit go;
        @(negedge clock); drive(1'b0, 0, 0, 0); clear = 1'b1;
        @(negedge clock); clear = 1'b0;
        for (int c = 0; c < 42; c++) begin
            if (c > 0) @(negedge clock);
            total++;
            if (ov !== exp_valid || ov_s !== exp_valid) begin
                bad++;
                $display("[TB] FAIL b2b valid: got %b/%b want %b", ov, ov_s, exp_valid);
            end
            if (exp_valid) begin
                total++;
                if ({och, oval, oovf} !== {exp_ch, exp_w, exp_ovf} || {och_s, oval_s, oovf_s} !== {exp_ch, exp_s, exp_ovf_s}) begin
                    bad++;
                    $display("[TB] FAIL b2b result: got ch%0d %0d/%0d want ch%0d %0d/%0d",
                             och, $signed(oval), $signed(oval_s), exp_ch, $signed(exp_w), $signed(exp_s));
                end
            end
            total++;
            if (accv !== exp_flat || accv_s !== exp_flat_s) begin
                bad++;
                $display("[TB] FAIL b2b acc: got %h/%h want %h/%h", accv, accv_s, exp_flat, exp_flat_s);
            end
            if (c < 30)      drive(1'b1, 3, 0, 1);
            else if (c < 34) drive(1'b0, 0, 0, 0);
            else             drive(1'b1, c % 4, 0, $urandom_range(0, 255));
            if (c == 34) begin
                total++;
                if (count !== 10 || accv[31:24] !== 8'(count)) begin
                    bad++;
                    $display("[TB] FAIL b2b count: got accepts=%0d ch3=%0d want accepts=10 ch3=accepts", count, accv[31:24]);
                end
                count = 0;
            end
            #1;
            go = model_ready(clear, in_ch);
            total++;
            if (rdy !== go || rdy_s !== go) begin
                bad++;
                $display("[TB] FAIL b2b ready: got %b/%b want %b", rdy, rdy_s, go);
            end
            if (in_valid && go) count++;
        end
        total++;
        if (count !== 8) begin
            bad++;
            $display("[TB] FAIL rotation accepts: got %0d want 8", count);
        end
    endtask

    task automatic test_random();
        bit go;
        bit holding = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            total++;
            if (ov !== exp_valid || ov_s !== exp_valid) begin
                bad++;
                $display("[TB] FAIL random valid: got %b/%b want %b", ov, ov_s, exp_valid);
            end
            if (exp_valid) begin
                total++;
                if ({och, oval, oovf} !== {exp_ch, exp_w, exp_ovf} || {och_s, oval_s, oovf_s} !== {exp_ch, exp_s, exp_ovf_s}) begin
                    bad++;
                    $display("[TB] FAIL random result: got ch%0d %0d/%0d ovf %b/%b want ch%0d %0d/%0d ovf %b/%b",
                             och, $signed(oval), $signed(oval_s), oovf, oovf_s, exp_ch, $signed(exp_w), $signed(exp_s), exp_ovf, exp_ovf_s);
                end
            end
            total++;
            if (accv !== exp_flat || accv_s !== exp_flat_s) begin
                bad++;
                $display("[TB] FAIL random acc: got %h/%h want %h/%h", accv, accv_s, exp_flat, exp_flat_s);
            end
            if (c >= 294) begin
                drive(1'b0, 0, 0, 0);
            end else if (!holding) begin
                if ($urandom_range(0, 3) != 0)
                    drive(1'b1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
                else
                    drive(1'b0, 0, 0, 0);
            end
            #1;
            go = model_ready(clear, in_ch);
            total++;
            if (rdy !== go || rdy_s !== go) begin
                bad++;
                $display("[TB] FAIL random ready: got %b/%b want %b", rdy, rdy_s, go);
            end
            holding = in_valid && !go;
        end
    endtask

    task automatic test_clear_inflight();
        @(negedge clock); drive(1'b1, 0, 0, 7); #1;
        total++;
        if (rdy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL inflight ready ch0: got %b want 1", rdy);
        end
        @(negedge clock); drive(1'b1, 1, 0, 9); #1;
        total++;
        if (rdy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL inflight ready ch1: got %b want 1", rdy);
        end
        @(negedge clock); drive(1'b0, 0, 0, 0); clear = 1'b1;
        @(negedge clock); clear = 1'b0; #1;
        total++;
        if (rdy !== 1'b1 || rdy_s !== 1'b1) begin
            bad++;
            $display("[TB] FAIL inflight ready after clear: got %b/%b want 1", rdy, rdy_s);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            total++;
            if (ov !== 1'b0 || ov_s !== 1'b0) begin
                bad++;
                $display("[TB] FAIL inflight valid: got %b/%b want 0", ov, ov_s);
            end
            total++;
            if (accv !== '0 || accv_s !== '0) begin
                bad++;
                $display("[TB] FAIL inflight acc: got %h/%h want 0", accv, accv_s);
            end
        end
    endtask

    task automatic test_pipe0();
        @(negedge clock);
        p_valid = 1'b1; p_ch = 2'd0; p_op = 2'd0; p_val = 8'd3; #1;
        total++;
        if (p_rdy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL p0 ready ch0: got %b want 1", p_rdy);
        end
        @(negedge clock);
        total++;
        if (p_ov !== 1'b0) begin
            bad++;
            $display("[TB] FAIL p0 early valid: got %b want 0", p_ov);
        end
        p_ch = 2'd1; p_val = 8'd4; #1;
        total++;
        if (p_rdy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL p0 ready ch1: got %b want 1", p_rdy);
        end
        @(negedge clock);
        total++;
        if ({p_ov, p_och, p_oval, p_oovf} !== {1'b1, 2'd0, 8'd3, 1'b0}) begin
            bad++;
            $display("[TB] FAIL p0 first: got v%b ch%0d %0d ovf%b want v1 ch0 3 ovf0", p_ov, p_och, p_oval, p_oovf);
        end
        p_valid = 1'b0;
        @(negedge clock);
        total++;
        if ({p_ov, p_och, p_oval, p_oovf} !== {1'b1, 2'd1, 8'd4, 1'b0}) begin
            bad++;
            $display("[TB] FAIL p0 second: got v%b ch%0d %0d ovf%b want v1 ch1 4 ovf0", p_ov, p_och, p_oval, p_oovf);
        end
        p_valid = 1'b1; p_ch = 2'd3; p_val = 8'd1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (p_rdy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL p0 out-of-range ready: got %b want 0", p_rdy);
            end
            @(negedge clock);
            total++;
            if (p_ov !== 1'b0) begin
                bad++;
                $display("[TB] FAIL p0 out-of-range valid: got %b want 0", p_ov);
            end
        end
        p_valid = 1'b0;
        total++;
        if (p_acc !== 24'h00_04_03) begin
            bad++;
            $display("[TB] FAIL p0 acc: got %h want 000403", p_acc);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_clear_inflight();
        test_pipe0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
